// File: rtl/frame_seq_pkg.sv
// Shared types for the frame sequencer: display modes, FSM states and mode stepping.
package frame_seq_pkg;

  localparam int NUM_MODES = 4;

  typedef enum logic [1:0] {
    NOISE_ANIM   = 2'd0,
    NOISE_FROZEN = 2'd1,
    NOISE_PAUSED = 2'd2,
    BLANK        = 2'd3
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic mode_t next_mode(input mode_t m);
    if (m == mode_t'(2'(NUM_MODES - 1)))
      return NOISE_ANIM;
    else
      return mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// 0->1 edge detector for an already-synchronized level; pulse is combinational
// from the current input and the registered previous sample.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset)
      prev <= 1'b0;
    else
      prev <= din;
  end

  assign pulse = din & ~prev;

endmodule

// File: rtl/frame_sequencer.sv
// Frame-locked mode sequencer for the noise LFSR bank; all outputs registered, one cycle
// after the beam boundary input. Automatic mode advance is compiled in with FRAME_SEQ_AUTO_EN.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 60,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       hpos,
  input  logic [9:0]       vpos,
  input  logic             display_on,
  input  logic             step_req,
  output logic [1:0]       mode,
  output logic             frame_start,
  output logic             lfsr_run,
  output logic             lfsr_load,
  output logic             rgb_blank,
  output logic [CNT_W-1:0] frame_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  mode_t  mode_q;
  logic   pending;
  logic   step_edge;
  logic   boundary;
  logic   auto_hit;
  logic   advance;
  mode_t  new_mode;

  // display_on is combined with rgb_blank by the top-level RGB mux, not here.
  logic   unused_display_on;
  assign unused_display_on = display_on;

  rise_detect u_step_edge (
    .clk   (clk),
    .reset (reset),
    .din   (step_req),
    .pulse (step_edge)
  );

  assign boundary = (hpos == 10'd0) && (vpos == 10'd0);

`ifdef FRAME_SEQ_AUTO_EN
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(FRAMES_PER_STEP - 1);
  assign auto_hit = (frame_count == CNT_TERM);
`else
  localparam int unused_frames_per_step = FRAMES_PER_STEP;
  assign auto_hit = 1'b0;
`endif

  assign advance  = pending | auto_hit;
  assign new_mode = advance ? next_mode(mode_q) : mode_q;
  assign mode     = mode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= NOISE_ANIM;
      frame_start <= 1'b0;
      lfsr_run    <= 1'b0;
      lfsr_load   <= 1'b0;
      rgb_blank   <= 1'b1;
      frame_count <= '0;
      pending     <= 1'b0;
    end else begin
      frame_start <= boundary;
      lfsr_load   <= 1'b0;
      case (state)
        IDLE: begin
          // Step edges are dropped until the first frame has been seen.
          if (boundary) begin
            state       <= RUN;
            mode_q      <= NOISE_ANIM;
            lfsr_load   <= 1'b1;
            lfsr_run    <= 1'b1;
            rgb_blank   <= 1'b0;
            frame_count <= '0;
          end
        end
        RUN: begin
          if (boundary) begin
            mode_q    <= new_mode;
            lfsr_run  <= (new_mode == NOISE_ANIM) || (new_mode == NOISE_FROZEN);
            rgb_blank <= (new_mode == BLANK);
            lfsr_load <= (new_mode == NOISE_FROZEN);
            if (advance) begin
              frame_count <= '0;
              // An edge arriving with the consuming boundary is kept for the next frame.
              pending     <= step_edge;
            end else begin
              frame_count <= (frame_count == CNT_MAX) ? frame_count : frame_count + 1'b1;
              pending     <= pending | step_edge;
            end
          end else begin
            pending <= pending | step_edge;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: driver pushes model expectations, monitor pops and compares.
module tb_frame_sequencer;

  localparam int FPS  = 3;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
`ifdef FRAME_SEQ_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [9:0]    hpos;
  logic [9:0]    vpos;
  logic          display_on;
  logic          step_req;
  logic [1:0]    mode;
  logic          frame_start;
  logic          lfsr_run;
  logic          lfsr_load;
  logic          rgb_blank;
  logic [CW-1:0] frame_count;

  frame_sequencer #(.FRAMES_PER_STEP(FPS), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .hpos        (hpos),
    .vpos        (vpos),
    .display_on  (display_on),
    .step_req    (step_req),
    .mode        (mode),
    .frame_start (frame_start),
    .lfsr_run    (lfsr_run),
    .lfsr_load   (lfsr_load),
    .rgb_blank   (rgb_blank),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          fs;
    logic          load;
    logic          run;
    logic          blank;
    logic [1:0]    mode;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: has a frame been seen, current mode, frames in mode, pending step.
  bit m_started = 0;
  int m_mode    = 0;
  int m_fc      = 0;
  bit m_pending = 0;
  bit m_prev    = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit bnd, input bit stp);
    exp_t e;
    bit   rise;
    bit   adv;
    @(negedge clk);
    reset      = rst;
    step_req   = stp;
    display_on = 1'($urandom_range(0, 1));
    if (bnd) begin
      hpos = 10'd0;
      vpos = 10'd0;
    end else begin
      case ($urandom_range(0, 2))
        0: begin hpos = 10'd0; vpos = 10'($urandom_range(1, 1023)); end
        1: begin hpos = 10'($urandom_range(1, 1023)); vpos = 10'd0; end
        default: begin
          hpos = 10'($urandom_range(1, 1023));
          vpos = 10'($urandom_range(0, 1023));
        end
      endcase
    end
    e = '0;
    if (rst) begin
      m_started = 0; m_mode = 0; m_fc = 0; m_pending = 0; m_prev = 0;
    end else begin
      rise   = stp && !m_prev;
      m_prev = stp;
      e.fs   = bnd;
      if (bnd && !m_started) begin
        m_started = 1; m_mode = 0; m_fc = 0;
        e.load = 1'b1;
      end else if (bnd) begin
        adv = m_pending || (AUTO && m_fc == FPS - 1);
        if (adv) begin
          m_mode    = (m_mode + 1) % 4;
          m_fc      = 0;
          m_pending = rise;
        end else begin
          if (m_fc < CMAX) m_fc++;
          m_pending = m_pending || rise;
        end
        e.load = (m_mode == 1);
      end else if (m_started) begin
        m_pending = m_pending || rise;
      end
    end
    e.mode  = 2'(m_mode);
    e.fc    = CW'(m_fc);
    e.run   = m_started && (m_mode < 2);
    e.blank = !m_started || (m_mode == 3);
    q.push_back(e);
  endtask

  // gap non-boundary cycles carrying `edges` step edges, then one boundary cycle
  task automatic frame(input int gap, input int edges);
    for (int i = 0; i < gap; i++)
      cycle(0, 0, (i < 2 * edges) ? (i % 2 == 1) : 1'b0);
    cycle(0, 1, 0);
  endtask

  logic prev_load = 1'b0;

  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("frame_start", 8'(frame_start), 8'(e.fs));
        chk("lfsr_load",   8'(lfsr_load),   8'(e.load));
        chk("lfsr_run",    8'(lfsr_run),    8'(e.run));
        chk("rgb_blank",   8'(rgb_blank),   8'(e.blank));
        chk("mode",        8'(mode),        8'(e.mode));
        chk("frame_count", 8'(frame_count), 8'(e.fc));
        chk("load_consecutive", 8'(lfsr_load && prev_load), 8'd0);
        prev_load = lfsr_load;
      end
    end
  end

  initial begin
    bit stp_l;
    bit last_bnd;
    bit bnd;
    reset = 1'b1; hpos = 10'd5; vpos = 10'd5; display_on = 1'b0; step_req = 1'b0;

    repeat (3) cycle(1, 0, 0);
    // idle: no boundary for 100 cycles, step edges must be discarded
    for (int i = 0; i < 100; i++) cycle(0, 0, ((i / 7) % 2) == 1);
    cycle(0, 0, 0);
    cycle(0, 1, 0);

    // free-running frames: auto advance or frame_count saturation
    repeat (9) frame(5, 0);
    // two edges in one frame advance once
    frame(8, 2);
    frame(6, 0);
    // edge coincident with the boundary is deferred one frame
    cycle(0, 0, 0);
    cycle(0, 1, 1);
    frame(4, 0);
    frame(4, 0);

    // reach mode 2, arm a step, then reset mid-frame
    for (int k = 0; k < 12 && m_mode != 2; k++) frame(4, 1);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    cycle(1, 0, 1);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    frame(3, 0);
    frame(3, 0);

    // randomized traffic
    stp_l = 0;
    last_bnd = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) stp_l = ~stp_l;
      bnd = !last_bnd && ($urandom_range(0, 5) == 0);
      cycle($urandom_range(0, 599) == 0, bnd, stp_l);
      last_bnd = bnd;
    end
    cycle(0, 0, 0);
    cycle(0, 0, 0);

    @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
